// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2, never below 1 so single-value fields still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

  localparam int ARB_NREQ_DEF  = 4;
  localparam int ARB_BURST_DEF = 4;
  localparam int ARB_GRANT_W   = clog2(ARB_NREQ_DEF);
  localparam int ARB_BURST_W   = clog2(ARB_BURST_DEF);

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first asserted request strictly after 'last', wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last,
  output logic            any,
  output logic [GW-1:0]   idx
);

  // Scan from farthest to nearest so the nearest candidate after 'last' wins.
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) idx = GW'((int'(last) + k) % NREQ);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ requesters.
// Each grant carries up to BURST words; writes are throttled from fifo_count
// plus the write still in flight so the FIFO can never overflow.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int NREQ  = ARB_NREQ_DEF,
  parameter int BURST = ARB_BURST_DEF,
  parameter int CNT_W = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         ack,
  input  logic [CNT_W-1:0]        fifo_count,
  output logic                    fifo_we,
  output logic [WIDTH-1:0]        fifo_din,
  output logic [clog2(NREQ)-1:0]  grant_id,
  output logic                    busy
);

  localparam int GW = clog2(NREQ);
  localparam int BW = clog2(BURST);

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              we_q, we_d;
  logic [WIDTH-1:0]  din_q, din_d;

  logic              pick_any;
  logic [GW-1:0]     pick_idx;
  logic [CNT_W:0]    occ;
  logic              space;
  logic              xfer;

  rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // One extra bit so count + in-flight write cannot wrap.
  assign occ   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, we_q};
  assign space = (occ < (CNT_W+1)'(DEPTH));

  // Next-state, ack and write-register decode for the IDLE/GRANT machine.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    we_d    = 1'b0;
    din_d   = din_q;
    ack     = '0;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        xfer         = req[grant_q] & space;
        ack[grant_q] = xfer;
        if (!req[grant_q]) begin
          state_d = IDLE;
          last_d  = grant_q;
        end else if (xfer) begin
          we_d  = 1'b1;
          din_d = req_data[int'(grant_q)*WIDTH +: WIDTH];
          if (burst_q == BW'(BURST-1)) begin
            state_d = IDLE;
            last_d  = grant_q;
          end else begin
            burst_d = burst_q + BW'(1);
          end
        end
        // A full FIFO with req held simply stalls here without counting.
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset leaves requester 0 highest priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NREQ-1);
      burst_q <= '0;
      we_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      we_q    <= we_d;
      din_q   <= din_d;
    end
  end

  assign fifo_we  = we_q;
  assign fifo_din = din_q;
  assign grant_id = grant_q;
  assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter with a transaction-level
// reference model and a FIFO occupancy model acting as the consumer.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
  localparam int NREQ  = ARB_NREQ_DEF;
  localparam int BURST = ARB_BURST_DEF;
  localparam int CNT_W = 64;
  localparam int GW    = ARB_GRANT_W;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_we;
  logic [WIDTH-1:0]      fifo_din;
  logic [GW-1:0]         grant_id;
  logic                  busy;

  fifo_wr_arbiter #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NREQ  (NREQ),
    .BURST (BURST),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .fifo_count (fifo_count),
    .fifo_we    (fifo_we),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  int checks;
  int errors;

  // Stimulus side: requesters and the FIFO consumer.
  logic [NREQ-1:0] want;
  int              seq [NREQ];
  int              cnt_model;
  int              max_cnt;
  bit              we_prev, rd_prev, drain, soak, busy_prev;
  int              run_len, wr_count;
  int              glog [$];
  int              runs [$];
  int              rr_exp [5] = '{0, 1, 2, 3, 0};

  // Reference model: who owns the port and how many words it has moved.
  bit                   m_act;
  int                   m_gid, m_last;
  logic [ARB_BURST_W:0] m_words;
  bit                   m_we;
  logic [WIDTH-1:0]     m_din;
  int                   exp_seq [NREQ];
  logic [NREQ-1:0]      e_ack;
  int                   w_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at +2, sample at +6, compare process runs at the negedge.
  task automatic do_cycle();
    @(posedge clk);
    #2;
    cnt_model = cnt_model + (we_prev ? 1 : 0) - (rd_prev ? 1 : 0);
    if (cnt_model > max_cnt) max_cnt = cnt_model;
    fifo_count = CNT_W'(cnt_model);
    req = want;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = {32'(i), 32'(seq[i])};
    #4;
    we_prev = fifo_we;
    rd_prev = drain && (cnt_model > 0) && (!soak || ($urandom_range(0, 2) != 0));
    if (fifo_we) begin
      wr_count++;
      run_len++;
    end else if (run_len > 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
    if (busy && !busy_prev) glog.push_back(int'(grant_id));
    busy_prev = busy;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && ack[i]) begin
        seq[i]++;
        if (soak) want[i] = ($urandom_range(0, 4) != 0);
      end else if (soak) begin
        if (want[i]) want[i] = ($urandom_range(0, 19) != 0);
        else         want[i] = ($urandom_range(0, 2) == 0);
      end
    end
  endtask

  // Compare DUT against the model every cycle, then advance the model.
  always @(negedge clk) begin
    if (!reset) begin
      m_act   = 1'b0;
      m_gid   = 0;
      m_last  = NREQ - 1;
      m_words = '0;
      m_we    = 1'b0;
      m_din   = '0;
      for (int i = 0; i < NREQ; i++) exp_seq[i] = 0;
      chk("rst_ack", ack, 0);
      chk("rst_we", fifo_we, 0);
      chk("rst_din", fifo_din, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_busy", busy, 0);
    end else begin
      e_ack = '0;
      if (m_act && req[m_gid] && (int'(fifo_count) + (m_we ? 1 : 0) < DEPTH)) e_ack[m_gid] = 1'b1;
      chk("ack", ack, e_ack);
      chk("busy", busy, m_act);
      chk("grant_id", grant_id, m_gid);
      chk("fifo_we", fifo_we, m_we);
      if (m_we) chk("fifo_din", fifo_din, m_din);
      if (fifo_we) begin
        chk("no_write_when_full", (int'(fifo_count) < DEPTH), 1);
        w_id = int'(fifo_din[63:32]);
        if (w_id < NREQ) begin
          chk("word_order", fifo_din[31:0], exp_seq[w_id]);
          exp_seq[w_id]++;
        end else begin
          checks++;
          errors++;
          $display("FAIL word_id actual=%0d required<%0d", w_id, NREQ);
        end
      end
      if (m_act) begin
        m_we = 1'b0;
        if (!req[m_gid]) begin
          m_act  = 1'b0;
          m_last = m_gid;
        end else if (e_ack[m_gid]) begin
          m_we    = 1'b1;
          m_din   = req_data[m_gid*WIDTH +: WIDTH];
          m_words = m_words + 1'b1;
          if (int'(m_words) == BURST) begin
            m_act  = 1'b0;
            m_last = m_gid;
          end
        end
      end else begin
        m_we = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          if (!m_act && req[(m_last + k) % NREQ]) begin
            m_act   = 1'b1;
            m_gid   = (m_last + k) % NREQ;
            m_words = '0;
          end
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; req = '0; req_data = '0; fifo_count = '0;
    want = '1; cnt_model = 0; max_cnt = 0;
    we_prev = 0; rd_prev = 0; drain = 1; soak = 0; busy_prev = 0;
    run_len = 0; wr_count = 0;
    for (int i = 0; i < NREQ; i++) seq[i] = 0;

    // Reset held with every requester asking.
    do_cycle();
    do_cycle();
    chk("reset_ack", ack, 0);
    chk("reset_we", fifo_we, 0);
    chk("reset_grant", grant_id, 0);
    chk("reset_busy", busy, 0);
    #1 reset = 1'b1;
    glog.delete();
    runs.delete();

    // Round robin with all requesters held and a consumer that keeps up.
    do_cycle();
    chk("first_grant_busy", busy, 1);
    chk("first_grant_id", grant_id, 0);
    repeat (26) do_cycle();
    chk("rr_grants_seen", (glog.size() >= 5), 1);
    if (glog.size() >= 5)
      for (int i = 0; i < 5; i++) chk("rr_order", glog[i], rr_exp[i]);
    chk("rr_runs_seen", (runs.size() >= 4), 1);
    if (runs.size() >= 4)
      for (int i = 0; i < 4; i++) chk("rr_burst_len", runs[i], BURST);

    // Backpressure: FIFO at 7 of 8, only requester 2.
    want = '0;
    repeat (4) do_cycle();
    drain = 0; rd_prev = 0; cnt_model = 7; want = 4'b0100;
    do_cycle();
    chk("bp_idle", busy, 0);
    do_cycle();
    chk("bp_grant", grant_id, 2);
    chk("bp_ack_first", ack, 4'b0100);
    wr_count = 0;
    do_cycle();
    chk("bp_write", fifo_we, 1);
    chk("bp_ack_inflight", ack, 0);
    do_cycle();
    chk("bp_full_count", fifo_count, 8);
    chk("bp_ack_full", ack, 0);
    chk("bp_no_write", fifo_we, 0);
    cnt_model = 6;
    do_cycle();
    chk("bp_ack_resume", ack, 4'b0100);
    drain = 1;
    repeat (3) do_cycle();
    chk("bp_burst_end", busy, 0);
    chk("bp_burst_words", wr_count, 4);

    // Early release by requester 1 after two words.
    want = '0;
    repeat (3) do_cycle();
    want = 4'b0010;
    do_cycle();
    do_cycle();
    chk("er_grant", grant_id, 1);
    chk("er_ack1", ack, 4'b0010);
    do_cycle();
    chk("er_ack2", ack, 4'b0010);
    want = 4'b1001;
    do_cycle();
    chk("er_drop_busy", busy, 1);
    chk("er_drop_ack", ack, 0);
    do_cycle();
    chk("er_idle", busy, 0);
    do_cycle();
    chk("er_next_grant", grant_id, 3);
    chk("er_next_busy", busy, 1);

    // Asynchronous reset between clock edges in the middle of a burst.
    do_cycle();
    chk("ar_mid_burst", busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("ar_ack", ack, 0);
    chk("ar_busy", busy, 0);
    chk("ar_we", fifo_we, 0);
    chk("ar_grant", grant_id, 0);
    chk("ar_din", fifo_din, 0);
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
    want = '1;
    do_cycle();
    do_cycle();
    #1 reset = 1'b1;
    do_cycle();
    chk("ar_restart_grant", grant_id, 0);
    chk("ar_restart_busy", busy, 1);

    // Random soak with a randomly draining consumer.
    soak = 1;
    repeat (10000) do_cycle();
    chk("fifo_never_over", (max_cnt <= DEPTH), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
